or_16: RTL and testbench

16-bit bitwise OR unit for the gate-level datapath library. It produces a zero-latency combinational `a | b` result. Alongside it, it provides a registered copy with a valid strobe, zero/all-ones status flags, and an optional sticky OR accumulator. It is used wherever a 16-bit OR word is needed, either combinationally or pipelined.

---
 rtl/or_16_pkg.sv | 26 ++
 rtl/or_16_if.sv | 43 ++++
 rtl/or_16_acc.sv | 54 +++++
 rtl/or_16.sv | 112 +++++++++++
 tb/tb_or_16.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/or_16_pkg.sv
// ---------------------------------------------------------------------------
// or_16_pkg
// Shared definitions for the 16-bit OR unit: word width, word type, the
// all-zeros / all-ones constants and the status-flag helper functions used
// by the registered path.
// ---------------------------------------------------------------------------
package or_16_pkg;

  localparam int WIDTH = 16;

  typedef logic [WIDTH-1:0] word_t;

  localparam word_t ALL_ONES  = '1;
  localparam word_t ALL_ZEROS = '0;

  // True when every bit of the word is clear.
  function automatic logic is_zero(input word_t w);
    return (w == ALL_ZEROS);
  endfunction

  // True when every bit of the word is set.
  function automatic logic is_ones(input word_t w);
    return (w == ALL_ONES);
  endfunction

endpackage : or_16_pkg

// File: rtl/or_16_if.sv
// ---------------------------------------------------------------------------
// or_16_if
// Signal bundle for the OR unit. The clock and reset stay outside the
// bundle. The master drives operands and control; the slave (the OR unit)
// returns the combinational result, the registered result with its valid
// strobe and status flags, and the accumulator.
//   a, b      : operands
//   in_valid  : qualifies a/b for the registered path and accumulator
//   acc_en    : OR the current result into the accumulator
//   acc_clr   : clear the accumulator
//   out       : combinational a | b
//   out_q     : registered a | b
//   out_valid : out_q holds a new result this cycle
//   zero_q    : out_q is all zeros
//   ones_q    : out_q is all ones
//   acc       : sticky OR accumulator
// ---------------------------------------------------------------------------
interface or_16_if;
  import or_16_pkg::*;

  word_t a;
  word_t b;
  logic  in_valid;
  logic  acc_en;
  logic  acc_clr;
  word_t out;
  word_t out_q;
  logic  out_valid;
  logic  zero_q;
  logic  ones_q;
  word_t acc;

  modport master (
    output a, b, in_valid, acc_en, acc_clr,
    input  out, out_q, out_valid, zero_q, ones_q, acc
  );

  modport slave (
    input  a, b, in_valid, acc_en, acc_clr,
    output out, out_q, out_valid, zero_q, ones_q, acc
  );

endinterface : or_16_if

// File: rtl/or_16_acc.sv
// ---------------------------------------------------------------------------
// or_16_acc
// Sticky OR accumulator. Priority on each rising edge:
//   rst -> clear, else clr_i -> clear (the input that cycle is discarded),
//   else en_i & valid_i -> acc | data, else hold.
// Bits only ever set, so the value saturates at all-ones and never wraps.
// Ports:
//   clk     : rising-edge clock
//   rst     : synchronous active-high reset
//   clr_i   : clear request
//   en_i    : accumulate request
//   valid_i : qualifies data_i
//   data_i  : word to OR in (already a | b)
//   acc_o   : accumulator value
// ---------------------------------------------------------------------------
module or_16_acc
  import or_16_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  clr_i,
  input  logic  en_i,
  input  logic  valid_i,
  input  word_t data_i,
  output word_t acc_o
);

  word_t acc_q;
  word_t acc_d;

  // Next accumulator value: clear beats accumulate, accumulate needs valid.
  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = ALL_ZEROS;
    end else if (en_i && valid_i) begin
      acc_d = acc_q | data_i;
    end else begin
      acc_d = acc_q;
    end
  end

  // Accumulator register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= ALL_ZEROS;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule : or_16_acc

// File: rtl/or_16.sv
// ---------------------------------------------------------------------------
// or_16
// 16-bit bitwise OR unit. Provides a zero-latency combinational a | b, a
// registered copy with a valid strobe and zero/all-ones status flags, and an
// optional sticky OR accumulator.
// Configuration macro: OR_16_ACC_EN
//   defined   -> accumulator implemented (or_16_acc instance)
//   undefined -> acc tied to zero, acc_en/acc_clr ignored, ports unchanged
// Ports (declaration order allows positional (out, a, b) use):
//   out       : combinational a | b, independent of clk/rst
//   a, b      : operands
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset
//   in_valid  : qualifies a/b for the registered path and accumulator
//   acc_en    : OR the current result into the accumulator
//   acc_clr   : clear the accumulator (wins over acc_en)
//   out_q     : registered a | b, holds while in_valid is low
//   out_valid : out_q was loaded on the previous edge
//   zero_q    : out_q == 16'h0000
//   ones_q    : out_q == 16'hFFFF
//   acc       : sticky OR accumulator
// ---------------------------------------------------------------------------
module or_16
  import or_16_pkg::*;
(
  output word_t out,
  input  word_t a,
  input  word_t b,
  input  logic  clk,
  input  logic  rst,
  input  logic  in_valid,
  input  logic  acc_en,
  input  logic  acc_clr,
  output word_t out_q,
  output logic  out_valid,
  output logic  zero_q,
  output logic  ones_q,
  output word_t acc
);

  word_t res_s;

  word_t res_q;
  word_t res_d;
  logic  vld_q;
  logic  vld_d;
  logic  zero_flag_q;
  logic  zero_flag_d;
  logic  ones_flag_q;
  logic  ones_flag_d;

  assign res_s = a | b;
  assign out   = res_s;

  // Registered-path next state: load on in_valid, otherwise hold the data
  // and flags while the strobe drops.
  always_comb begin
    res_d       = res_q;
    zero_flag_d = zero_flag_q;
    ones_flag_d = ones_flag_q;
    vld_d       = 1'b0;
    if (in_valid) begin
      res_d       = res_s;
      zero_flag_d = is_zero(res_s);
      ones_flag_d = is_ones(res_s);
      vld_d       = 1'b1;
    end else begin
      res_d       = res_q;
      zero_flag_d = zero_flag_q;
      ones_flag_d = ones_flag_q;
      vld_d       = 1'b0;
    end
  end

  // Registered result, strobe and flags with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_q       <= ALL_ZEROS;
      vld_q       <= 1'b0;
      zero_flag_q <= 1'b0;
      ones_flag_q <= 1'b0;
    end else begin
      res_q       <= res_d;
      vld_q       <= vld_d;
      zero_flag_q <= zero_flag_d;
      ones_flag_q <= ones_flag_d;
    end
  end

  assign out_q     = res_q;
  assign out_valid = vld_q;
  assign zero_q    = zero_flag_q;
  assign ones_q    = ones_flag_q;

`ifdef OR_16_ACC_EN
  or_16_acc u_acc (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (acc_clr),
    .en_i    (acc_en),
    .valid_i (in_valid),
    .data_i  (res_s),
    .acc_o   (acc)
  );
`else
  // Accumulator controls are accepted but have no effect in this build.
  logic unused_acc_ctrl_s;
  assign unused_acc_ctrl_s = acc_en | acc_clr;
  assign acc               = ALL_ZEROS;
`endif

endmodule : or_16

// File: tb/tb_or_16.sv
// ---------------------------------------------------------------------------
// tb_or_16
// Self-checking bench for or_16. Expected registered results are pushed to a
// scoreboard queue when stimulus is driven and popped when out_valid rises.
// Inputs change on the falling edge; outputs are sampled 1 time unit after
// the rising edge. Accumulator expectations follow OR_16_ACC_EN.
// ---------------------------------------------------------------------------
module tb_or_16;
  import or_16_pkg::*;

  typedef struct packed {
    word_t res;
    logic  zero;
    logic  ones;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  or_16_if bus ();

  or_16 dut (
    .out       (bus.out),
    .a         (bus.a),
    .b         (bus.b),
    .clk       (clk),
    .rst       (rst),
    .in_valid  (bus.in_valid),
    .acc_en    (bus.acc_en),
    .acc_clr   (bus.acc_clr),
    .out_q     (bus.out_q),
    .out_valid (bus.out_valid),
    .zero_q    (bus.zero_q),
    .ones_q    (bus.ones_q),
    .acc       (bus.acc)
  );

  always #5 clk = ~clk;

  exp_t  sb_q[$];
  word_t m_out  = 16'h0000;
  logic  m_zero = 1'b0;
  logic  m_ones = 1'b0;
  logic  m_vld  = 1'b0;
  word_t m_acc  = 16'h0000;
  int    errors = 0;
  int    checks = 0;

  // Drive one cycle of stimulus on the falling edge and update the model.
  task automatic drive(input word_t a, input word_t b, input logic v,
                       input logic en, input logic clr, input logic r);
    exp_t e;
    @(negedge clk);
    rst = r;
    bus.a = a;
    bus.b = b;
    bus.in_valid = v;
    bus.acc_en = en;
    bus.acc_clr = clr;
    if (r) begin
      sb_q.delete();
      m_out = 16'h0000; m_zero = 1'b0; m_ones = 1'b0; m_vld = 1'b0; m_acc = 16'h0000;
    end else begin
      m_vld = v;
      if (v) begin
        m_out  = a | b;
        m_zero = (m_out == 16'h0000);
        m_ones = (m_out == 16'hFFFF);
        e.res = m_out; e.zero = m_zero; e.ones = m_ones;
        sb_q.push_back(e);
      end
`ifdef OR_16_ACC_EN
      if (clr) m_acc = 16'h0000;
      else if (en && v) m_acc = m_acc | a | b;
`endif
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    drive(16'h1234, 16'h8001, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    drive(16'h1234, 16'h8001, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    checks++;
    if ({bus.out_q, bus.out_valid, bus.zero_q, bus.ones_q, bus.acc} !== {16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000}) begin
      errors++;
      $display("FAIL reset_state: got out_q=%h vld=%b z=%b o=%b acc=%h, expected 0000 0 0 0 0000",
               bus.out_q, bus.out_valid, bus.zero_q, bus.ones_q, bus.acc);
    end
    checks++;
    if (bus.out !== 16'h9235) begin
      errors++;
      $display("FAIL reset_comb_out: got %h expected 9235", bus.out);
    end
  endtask

  task automatic test_basic;
    word_t av[5] = '{16'h0000, 16'hE000, 16'h000C, 16'h0000, 16'h1234};
    word_t bv[5] = '{16'hFFFF, 16'hA000, 16'hE000, 16'h0000, 16'h4321};
    word_t ev[5] = '{16'hFFFF, 16'hE000, 16'hE00C, 16'h0000, 16'h5335};
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      drive(av[i], bv[i], 1'b1, 1'b0, 1'b0, 1'b0);
      #1;
      checks++;
      if (bus.out !== ev[i]) begin
        errors++;
        $display("FAIL comb_out[%0d]: got %h expected %h", i, bus.out, ev[i]);
      end
      tick();
      checks++;
      if (bus.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL basic_valid[%0d]: got %b expected 1", i, bus.out_valid);
      end
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL basic_sb_empty[%0d]: got empty queue expected entry", i);
      end else begin
        e = sb_q.pop_front();
        checks++;
        if ({bus.out_q, bus.zero_q, bus.ones_q} !== {e.res, e.zero, e.ones}) begin
          errors++;
          $display("FAIL basic_out_q[%0d]: got %h z=%b o=%b expected %h z=%b o=%b",
                   i, bus.out_q, bus.zero_q, bus.ones_q, e.res, e.zero, e.ones);
        end
        checks++;
        if ({bus.out_q, bus.zero_q, bus.ones_q} !== {ev[i], (ev[i] == 16'h0000), (ev[i] == 16'hFFFF)}) begin
          errors++;
          $display("FAIL basic_const[%0d]: got %h expected %h", i, bus.out_q, ev[i]);
        end
      end
    end
  endtask

  task automatic test_hold;
    // The last basic vector left out_q = 5335; drop in_valid with new operands.
    drive(16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checks++;
    if ({bus.out_valid, bus.out_q, bus.zero_q, bus.ones_q} !== {1'b0, 16'h5335, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL hold: got vld=%b out_q=%h z=%b o=%b expected 0 5335 0 0",
               bus.out_valid, bus.out_q, bus.zero_q, bus.ones_q);
    end
    // Zero result then hold: zero flag must stay set.
    drive(16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    void'(sb_q.pop_front());
    drive(16'h00F0, 16'h0F00, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checks++;
    if ({bus.out_valid, bus.out_q, bus.zero_q, bus.ones_q} !== {m_vld, m_out, m_zero, m_ones}) begin
      errors++;
      $display("FAIL hold_zero: got vld=%b out_q=%h z=%b o=%b expected %b %h %b %b",
               bus.out_valid, bus.out_q, bus.zero_q, bus.ones_q, m_vld, m_out, m_zero, m_ones);
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    for (int i = 0; i < 12; i++) begin
      drive(word_t'($urandom), word_t'($urandom), 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      checks++;
      if (bus.out_valid !== 1'b1 || sb_q.size() == 0) begin
        errors++;
        $display("FAIL b2b_valid[%0d]: got vld=%b queue=%0d expected 1 and entry", i, bus.out_valid, sb_q.size());
      end else begin
        e = sb_q.pop_front();
        checks++;
        if ({bus.out_q, bus.zero_q, bus.ones_q} !== {e.res, e.zero, e.ones}) begin
          errors++;
          $display("FAIL b2b_out_q[%0d]: got %h expected %h", i, bus.out_q, e.res);
        end
      end
    end
  endtask

  task automatic test_acc;
    word_t fv[3] = '{16'h0001, 16'h0100, 16'h8000};
    word_t exp_acc;
    drive(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(fv[i], 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
    end
`ifdef OR_16_ACC_EN
    exp_acc = 16'h8101;
`else
    exp_acc = 16'h0000;
`endif
    checks++;
    if (bus.acc !== exp_acc || bus.acc !== m_acc) begin
      errors++;
      $display("FAIL acc_sum: got %h expected %h", bus.acc, exp_acc);
    end
    // acc_en without in_valid must not change anything.
    drive(16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    checks++;
    if (bus.acc !== exp_acc) begin
      errors++;
      $display("FAIL acc_no_valid: got %h expected %h", bus.acc, exp_acc);
    end
    // Clear wins over enable; the input that cycle is discarded.
    drive(16'h00FF, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    checks++;
    if (bus.acc !== 16'h0000) begin
      errors++;
      $display("FAIL acc_clr_prio: got %h expected 0000", bus.acc);
    end
    // Saturation: all ones twice stays all ones (or zero without the feature).
    drive(16'hFFFF, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    drive(16'h0000, 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
`ifdef OR_16_ACC_EN
    exp_acc = 16'hFFFF;
`else
    exp_acc = 16'h0000;
`endif
    checks++;
    if (bus.acc !== exp_acc || bus.acc !== m_acc) begin
      errors++;
      $display("FAIL acc_saturate: got %h expected %h", bus.acc, exp_acc);
    end
    sb_q.delete();
  endtask

  task automatic test_rst_midstream;
    drive(16'hFFFF, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    checks++;
    if ({bus.out_valid, bus.ones_q} !== 2'b11) begin
      errors++;
      $display("FAIL pre_rst: got vld=%b o=%b expected 1 1", bus.out_valid, bus.ones_q);
    end
    sb_q.delete();
    drive(16'h5A5A, 16'h0F0F, 1'b1, 1'b1, 1'b0, 1'b1);
    #1;
    checks++;
    if (bus.out !== 16'h5F5F) begin
      errors++;
      $display("FAIL rst_comb_out: got %h expected 5F5F", bus.out);
    end
    tick();
    checks++;
    if ({bus.out_q, bus.out_valid, bus.zero_q, bus.ones_q, bus.acc} !== {16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000}) begin
      errors++;
      $display("FAIL rst_midstream: got out_q=%h vld=%b z=%b o=%b acc=%h, expected 0000 0 0 0 0000",
               bus.out_q, bus.out_valid, bus.zero_q, bus.ones_q, bus.acc);
    end
    checks++;
    if (bus.out !== 16'h5F5F) begin
      errors++;
      $display("FAIL rst_comb_after: got %h expected 5F5F", bus.out);
    end
    drive(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.a = 16'h0000;
    bus.b = 16'h0000;
    bus.in_valid = 1'b0;
    bus.acc_en = 1'b0;
    bus.acc_clr = 1'b0;
    test_reset();
    test_basic();
    test_hold();
    test_back_to_back();
    test_acc();
    test_rst_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_or_16
